// File: rtl/morra_cinese_param.sv
// Rock-paper-scissors match referee: scores valid rounds, enforces the no-repeat rule
// and ends the match on an early-win margin or when the configured round count is reached.
module morra_cinese_param #(
  parameter int MIN_ROUNDS = 4,
  parameter int WIN_MARGIN = 2,
  parameter bit NO_REPEAT  = 1'b1,
  parameter int CNT_W      = $clog2(15 + MIN_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             INIZIA,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  output logic [1:0]       MANCHE,
  output logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] PUNTI1,
  output logic [CNT_W-1:0] PUNTI2,
  output logic [CNT_W-1:0] TURNO
);

  typedef enum logic {ST_PLAY = 1'b0, ST_END = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MIN_R  = CNT_W'(MIN_ROUNDS);
  localparam logic [CNT_W-1:0] MARGIN = CNT_W'(WIN_MARGIN);

  state_t           state_r;
  logic [CNT_W-1:0] max_rounds_r;
  logic [CNT_W-1:0] turno_r;
  logic [CNT_W-1:0] punti1_r;
  logic [CNT_W-1:0] punti2_r;
  logic [1:0]       last_win_r;
  logic [1:0]       last_move_r;

  logic             repeat_s;
  logic             valid_s;
  logic [1:0]       winner_s;
  logic [CNT_W-1:0] turno_nxt_s;
  logic [CNT_W-1:0] punti1_nxt_s;
  logic [CNT_W-1:0] punti2_nxt_s;
  logic [CNT_W-1:0] diff_s;
  logic [1:0]       manche_s;
  logic [1:0]       partita_s;

  // 01 = a wins, 10 = b wins, 11 = draw (both moves assumed non-zero)
  function automatic logic [1:0] round_winner(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] res;
    if (a == b) begin
      res = 2'b11;
    end else if ((a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) ||
                 (a == 2'b10 && b == 2'b01)) begin
      res = 2'b01;
    end else begin
      res = 2'b10;
    end
    return res;
  endfunction

  // Round validation, score update preview and Mealy results
  always_comb begin
    repeat_s     = 1'b0;
    valid_s      = 1'b0;
    winner_s     = round_winner(PRIMO, SECONDO);
    turno_nxt_s  = turno_r;
    punti1_nxt_s = punti1_r;
    punti2_nxt_s = punti2_r;
    diff_s       = {CNT_W{1'b0}};
    manche_s     = 2'b00;
    partita_s    = 2'b00;

    if (NO_REPEAT && ((last_win_r == 2'b01 && PRIMO == last_move_r) ||
                      (last_win_r == 2'b10 && SECONDO == last_move_r))) begin
      repeat_s = 1'b1;
    end else begin
      repeat_s = 1'b0;
    end

    if (!INIZIA && state_r == ST_PLAY && PRIMO != 2'b00 && SECONDO != 2'b00 && !repeat_s) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end

    if (valid_s) begin
      manche_s    = winner_s;
      turno_nxt_s = turno_r + {{(CNT_W-1){1'b0}}, 1'b1};
      case (winner_s)
        2'b01:   punti1_nxt_s = punti1_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b10:   punti2_nxt_s = punti2_r + {{(CNT_W-1){1'b0}}, 1'b1};
        default: punti1_nxt_s = punti1_r;
      endcase

      if (punti1_nxt_s >= punti2_nxt_s) begin
        diff_s = punti1_nxt_s - punti2_nxt_s;
      end else begin
        diff_s = punti2_nxt_s - punti1_nxt_s;
      end

      // Early win takes priority over the round-limit verdict
      if (turno_nxt_s >= MIN_R && diff_s >= MARGIN) begin
        partita_s = (punti1_nxt_s > punti2_nxt_s) ? 2'b01 : 2'b10;
      end else if (turno_nxt_s == max_rounds_r) begin
        if (punti1_nxt_s > punti2_nxt_s) begin
          partita_s = 2'b01;
        end else if (punti2_nxt_s > punti1_nxt_s) begin
          partita_s = 2'b10;
        end else begin
          partita_s = 2'b11;
        end
      end else begin
        partita_s = 2'b00;
      end
    end else begin
      manche_s = 2'b00;
    end
  end

  // Match state, configuration and score registers
  always_ff @(posedge clk) begin
    if (INIZIA) begin
      state_r      <= ST_PLAY;
      max_rounds_r <= CNT_W'({PRIMO, SECONDO}) + MIN_R;
      turno_r      <= {CNT_W{1'b0}};
      punti1_r     <= {CNT_W{1'b0}};
      punti2_r     <= {CNT_W{1'b0}};
      last_win_r   <= 2'b00;
      last_move_r  <= 2'b00;
    end else if (valid_s) begin
      turno_r  <= turno_nxt_s;
      punti1_r <= punti1_nxt_s;
      punti2_r <= punti2_nxt_s;
      case (winner_s)
        2'b01: begin
          last_win_r  <= 2'b01;
          last_move_r <= PRIMO;
        end
        2'b10: begin
          last_win_r  <= 2'b10;
          last_move_r <= SECONDO;
        end
        default: last_win_r <= 2'b00;
      endcase
      if (partita_s != 2'b00) begin
        state_r <= ST_END;
      end else begin
        state_r <= ST_PLAY;
      end
    end else begin
      state_r <= state_r;
    end
  end

  assign MANCHE  = manche_s;
  assign PARTITA = partita_s;
  assign PUNTI1  = punti1_r;
  assign PUNTI2  = punti2_r;
  assign TURNO   = turno_r;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Scoreboard bench for morra_cinese_param: a default build and a build with the
// no-repeat rule disabled share the same stimulus; each step selects which one is checked.
module tb_morra_cinese_param;

  localparam int W = 5;

  typedef struct packed {
    logic         sel;
    logic [1:0]   m;
    logic [1:0]   p;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] t;
  } exp_t;

  logic         clk = 1'b0;
  logic         INIZIA;
  logic [1:0]   PRIMO;
  logic [1:0]   SECONDO;
  logic [1:0]   m0, p0, m1, p1;
  logic [W-1:0] a0, b0, t0, a1, b1, t1;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  morra_cinese_param dut (
    .clk(clk), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(m0), .PARTITA(p0), .PUNTI1(a0), .PUNTI2(b0), .TURNO(t0)
  );

  morra_cinese_param #(.NO_REPEAT(1'b0)) dut_nr (
    .clk(clk), .INIZIA(INIZIA), .PRIMO(PRIMO), .SECONDO(SECONDO),
    .MANCHE(m1), .PARTITA(p1), .PUNTI1(a1), .PUNTI2(b1), .TURNO(t1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Drive one cycle, check Mealy outputs before the edge and registers after it
  task automatic step(input logic s, input logic ini, input logic [1:0] pa, input logic [1:0] pb,
                      input logic [1:0] em, input logic [1:0] ep,
                      input int ea, input int eb, input int et);
    exp_t e;
    @(negedge clk);
    INIZIA  = ini;
    PRIMO   = pa;
    SECONDO = pb;
    exp_q.push_back('{sel: s, m: em, p: ep, a: W'(ea), b: W'(eb), t: W'(et)});
    #1;
    e = exp_q.pop_front();
    check_val("manche",  e.sel ? {6'd0, m1} : {6'd0, m0}, {6'd0, e.m});
    check_val("partita", e.sel ? {6'd0, p1} : {6'd0, p0}, {6'd0, e.p});
    @(posedge clk);
    #1;
    check_val("punti1", e.sel ? {3'd0, a1} : {3'd0, a0}, {3'd0, e.a});
    check_val("punti2", e.sel ? {3'd0, b1} : {3'd0, b0}, {3'd0, e.b});
    check_val("turno",  e.sel ? {3'd0, t1} : {3'd0, t0}, {3'd0, e.t});
  endtask

  initial begin
    INIZIA  = 1'b1;
    PRIMO   = 2'b00;
    SECONDO = 2'b01;

    // 13-round match: invalid moves and P2 repeating its winning rock
    step(1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1, 0, 1);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 1, 1, 2);
    step(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1, 1, 2);
    step(1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 2);
    step(1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 1, 2);

    // 5 rounds: early win for P2 at turno 4, then END ignores moves
    step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 0, 1, 1);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 2, 2);
    step(1'b0, 1'b0, 2'b10, 2'b11, 2'b10, 2'b00, 0, 3, 3);
    step(1'b0, 1'b0, 2'b11, 2'b10, 2'b01, 2'b10, 1, 3, 4);
    step(1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 1, 3, 4);

    // Draws count as valid rounds and clear the repeat restriction
    step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 1);
    step(1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 2);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 1, 3);
    step(1'b0, 1'b0, 2'b10, 2'b11, 2'b10, 2'b10, 0, 2, 4);

    // Tied match at the round limit
    step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 1);
    step(1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 2);
    step(1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 3);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 1, 4);
    step(1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b11, 1, 1, 5);

    // P2 replays winning rock: rejected in the default build, accepted without the rule
    step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 1, 1);
    step(1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 0, 1, 1);
    step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b1, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 1, 1);
    step(1'b1, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 2, 2);

    // P1 repeat rejected, then reset mid-match at 2-0
    step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1, 0, 1);
    step(1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 1, 0, 1);
    step(1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b00, 2, 0, 2);
    step(1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    step(1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
